// File: rtl/strela_ctrl_unit.sv
// STRELA CGRA control/status unit: MMIO register file, run sequencer, saturating
// performance counters and a maskable done interrupt.
module strela_ctrl_unit #(
    parameter int unsigned IN_NODES  = 4,
    parameter int unsigned OUT_NODES = 4,
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            reg_req_i,
    input  logic                            reg_we_i,
    input  logic [7:0]                      reg_addr_i,
    input  logic [31:0]                     reg_wdata_i,
    output logic [31:0]                     reg_rdata_o,
    output logic                            reg_rvalid_o,
    output logic [31:0]                     conf_addr_o,
    output logic [31:0]                     conf_size_o,
    output logic [1:0]                      sew_o,
    output logic [32*IN_NODES-1:0]          in_addr_o,
    output logic [32*IN_NODES-1:0]          in_size_o,
    output logic [32*OUT_NODES-1:0]         out_addr_o,
    output logic [32*OUT_NODES-1:0]         out_size_o,
    output logic [IN_NODES+OUT_NODES-1:0]   chan_en_o,
    output logic                            conf_start_o,
    input  logic                            conf_done_i,
    input  logic [IN_NODES+OUT_NODES-1:0]   chan_ready_i,
    output logic                            exec_start_o,
    input  logic [OUT_NODES-1:0]            out_done_i,
    input  logic                            stall_i,
    output logic                            busy_o,
    output logic                            irq_o
);
    localparam int unsigned NCH      = IN_NODES + OUT_NODES;
    localparam int unsigned BASE_OUT = 32'h20 + 8 * IN_NODES;
    localparam int unsigned BASE_CTR = BASE_OUT + 8 * OUT_NODES;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StConf = 3'd1,
        StWait = 3'd2,
        StExec = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic conf_start_q, conf_start_d, exec_start_q, exec_start_d;
    logic [31:0] conf_addr_q, conf_size_q;
    logic [1:0] sew_q;
    logic [NCH-1:0] mask_q;
    logic [IN_NODES-1:0][31:0] in_addr_q, in_size_q;
    logic [OUT_NODES-1:0][31:0] out_addr_q, out_size_q;
    logic irq_en_q, done_q;
    logic [CTR_WIDTH-1:0] ctr_bs_q, ctr_exec_q, ctr_stall_q;
    logic [31:0] rdata_q, rdata_d;
    logic rvalid_q;

    logic wr, rd, ctrl_wr, start_req, clr_req, idle, cfg_wr;
    logic [OUT_NODES-1:0] out_mask;

    assign wr        = reg_req_i & reg_we_i;
    assign rd        = reg_req_i & ~reg_we_i;
    assign ctrl_wr   = wr & (reg_addr_i == 8'h00);
    assign start_req = ctrl_wr & reg_wdata_i[0];
    assign clr_req   = ctrl_wr & reg_wdata_i[1];
    assign idle      = (state_q == StIdle);
    assign cfg_wr    = wr & idle;
    assign out_mask  = mask_q[NCH-1:IN_NODES];

    function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] v);
        return (v == CTR_MAX) ? v : v + CTR_WIDTH'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        conf_start_d = 1'b0;
        exec_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    if (conf_size_q != 32'd0) begin
                        state_d      = StConf;
                        conf_start_d = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StConf: if (conf_done_i) state_d = StWait;
            StWait: begin
                if (&(chan_ready_i | ~mask_q)) begin
                    state_d      = StExec;
                    exec_start_d = 1'b1;
                end
            end
            // out_done_i may still hold the previous run's level during the first cycle
            StExec: begin
                if (~|out_mask || (!exec_start_q && &(out_done_i | ~out_mask))) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            conf_start_q <= 1'b0;
            exec_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            conf_start_q <= conf_start_d;
            exec_start_q <= exec_start_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conf_addr_q <= '0;
            conf_size_q <= '0;
            sew_q       <= '0;
            mask_q      <= '0;
            in_addr_q   <= '0;
            in_size_q   <= '0;
            out_addr_q  <= '0;
            out_size_q  <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (cfg_wr) begin
                if (reg_addr_i == 8'h04) conf_addr_q <= reg_wdata_i;
                if (reg_addr_i == 8'h08) conf_size_q <= reg_wdata_i;
                if (reg_addr_i == 8'h0C) sew_q <= reg_wdata_i[1:0];
                if (reg_addr_i == 8'h10) mask_q <= reg_wdata_i[NCH-1:0];
                for (int unsigned i = 0; i < IN_NODES; i++) begin
                    if (reg_addr_i == 8'(32'h20 + 8 * i)) in_addr_q[i] <= reg_wdata_i;
                    if (reg_addr_i == 8'(32'h24 + 8 * i)) in_size_q[i] <= reg_wdata_i;
                end
                for (int unsigned j = 0; j < OUT_NODES; j++) begin
                    if (reg_addr_i == 8'(BASE_OUT + 8 * j)) out_addr_q[j] <= reg_wdata_i;
                    if (reg_addr_i == 8'(BASE_OUT + 4 + 8 * j)) out_size_q[j] <= reg_wdata_i;
                end
            end
            if (ctrl_wr) irq_en_q <= reg_wdata_i[2];
            // Completion outranks a same-cycle W1C so a finished run is never lost
            if (state_q == StDone) done_q <= 1'b1;
            else if ((idle && start_req) || (ctrl_wr && reg_wdata_i[3])) done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctr_bs_q    <= '0;
            ctr_exec_q  <= '0;
            ctr_stall_q <= '0;
        end else if (clr_req) begin
            ctr_bs_q    <= '0;
            ctr_exec_q  <= '0;
            ctr_stall_q <= '0;
        end else begin
            if (state_q == StConf) ctr_bs_q <= sat_inc(ctr_bs_q);
            if (state_q == StExec) ctr_exec_q <= sat_inc(ctr_exec_q);
            if (state_q == StExec && stall_i) ctr_stall_q <= sat_inc(ctr_stall_q);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (reg_addr_i == 8'h00) rdata_d = {25'd0, state_q, done_q, irq_en_q, 2'b00};
        if (reg_addr_i == 8'h04) rdata_d = conf_addr_q;
        if (reg_addr_i == 8'h08) rdata_d = conf_size_q;
        if (reg_addr_i == 8'h0C) rdata_d[1:0] = sew_q;
        if (reg_addr_i == 8'h10) rdata_d[NCH-1:0] = mask_q;
        for (int unsigned i = 0; i < IN_NODES; i++) begin
            if (reg_addr_i == 8'(32'h20 + 8 * i)) rdata_d = in_addr_q[i];
            if (reg_addr_i == 8'(32'h24 + 8 * i)) rdata_d = in_size_q[i];
        end
        for (int unsigned j = 0; j < OUT_NODES; j++) begin
            if (reg_addr_i == 8'(BASE_OUT + 8 * j)) rdata_d = out_addr_q[j];
            if (reg_addr_i == 8'(BASE_OUT + 4 + 8 * j)) rdata_d = out_size_q[j];
        end
        if (reg_addr_i == 8'(BASE_CTR)) rdata_d[CTR_WIDTH-1:0] = ctr_bs_q;
        if (reg_addr_i == 8'(BASE_CTR + 4)) rdata_d[CTR_WIDTH-1:0] = ctr_exec_q;
        if (reg_addr_i == 8'(BASE_CTR + 8)) rdata_d[CTR_WIDTH-1:0] = ctr_stall_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd;
            if (rd) rdata_q <= rdata_d;
        end
    end

    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;
    assign conf_addr_o  = conf_addr_q;
    assign conf_size_o  = conf_size_q;
    assign sew_o        = sew_q;
    assign in_addr_o    = in_addr_q;
    assign in_size_o    = in_size_q;
    assign out_addr_o   = out_addr_q;
    assign out_size_o   = out_size_q;
    assign chan_en_o    = mask_q;
    assign conf_start_o = conf_start_q;
    assign exec_start_o = exec_start_q;
    assign busy_o       = ~idle;
    assign irq_o        = done_q & irq_en_q;

endmodule
